// File: rtl/mipi_csi_packet_encoder.sv
// mipi_csi_packet_encoder: CSI-2 4-lane byte-domain packet transmitter (SoT, header+ECC, payload, CRC-16, LP gap)
module mipi_csi_packet_encoder #(
  parameter logic [1:0] VC             = 2'd0,
  parameter bit         FRAME_COUNT_EN = 1'b1,
  parameter int         LP_GAP_CYCLES  = 8
) (
  input  logic        clk_i,
  input  logic        reset_in,
  input  logic        cmd_valid_i,
  input  logic [1:0]  cmd_type_i,
  input  logic [5:0]  data_type_i,
  input  logic [15:0] word_count_i,
  output logic        cmd_ready_o,
  input  logic [31:0] data_i,
  input  logic        data_valid_i,
  output logic        data_ready_o,
  output logic [31:0] hs_data_o,
  output logic [3:0]  lane_valid_o,
  output logic        hs_request_o,
  output logic        underflow_o,
  output logic        cmd_error_o
);
  typedef enum logic [2:0] {IDLE, SOT, HDR, PAY, CRC, GAP} state_t;
  localparam logic [15:0] GAP_LAST = 16'(LP_GAP_CYCLES - 1);
  state_t      state;
  logic [15:0] frame_num, crc, wc, cnt, fn_next;
  logic [5:0]  dt;
  logic        is_long, wc_bad, rsv_err;
  logic [31:0] word;
  function automatic logic [7:0] ecc(input logic [23:0] d);
    return {2'b00, ^(d & 24'hEFFC00), ^(d & 24'hDF03F0), ^(d & 24'hB8E38E),
            ^(d & 24'h749A6D), ^(d & 24'hF2555B), ^(d & 24'hF12CB7)};
  endfunction
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [31:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 32; i++) r = (r[0] ^ d[i]) ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    return r;
  endfunction
  assign fn_next = (frame_num == 16'hFFFF) ? 16'd1 : frame_num + 16'd1;
  assign word    = data_valid_i ? data_i : 32'h0;
  // Packet sequencer: every output is registered; a starved payload word is sent as zeros so the burst never stalls
  always_ff @(posedge clk_i) begin
    if (!reset_in) begin
      state        <= IDLE;
      frame_num    <= 16'h0;
      crc          <= 16'hFFFF;
      wc           <= 16'h0;
      cnt          <= 16'h0;
      dt           <= 6'h0;
      is_long      <= 1'b0;
      wc_bad       <= 1'b0;
      rsv_err      <= 1'b0;
      cmd_ready_o  <= 1'b0;
      data_ready_o <= 1'b0;
      hs_data_o    <= 32'h0;
      lane_valid_o <= 4'h0;
      hs_request_o <= 1'b0;
      underflow_o  <= 1'b0;
      cmd_error_o  <= 1'b0;
    end else begin
      cmd_error_o  <= rsv_err | (state == SOT && wc_bad);
      rsv_err      <= 1'b0;
      hs_data_o    <= 32'h0;
      lane_valid_o <= 4'h0;
      hs_request_o <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid_i && cmd_ready_o) begin
            if (cmd_type_i == 2'd3) rsv_err <= 1'b1;
            else begin
              state       <= SOT;
              cmd_ready_o <= 1'b0;
              is_long     <= cmd_type_i == 2'd2;
              wc_bad      <= cmd_type_i == 2'd2 && word_count_i[1:0] != 2'd0;
              dt          <= cmd_type_i == 2'd2 ? data_type_i : {5'd0, cmd_type_i[0]};
              wc          <= cmd_type_i == 2'd2 ? {word_count_i[15:2], 2'b00} :
                             !FRAME_COUNT_EN ? 16'h0 : cmd_type_i[0] ? frame_num : fn_next;
              if (cmd_type_i == 2'd0) frame_num <= fn_next;
            end
          end else cmd_ready_o <= 1'b1;
        end
        SOT: begin
          hs_data_o    <= 32'hB8B8B8B8;
          lane_valid_o <= 4'hF;
          hs_request_o <= 1'b1;
          crc          <= 16'hFFFF;
          state        <= HDR;
        end
        HDR: begin
          hs_data_o    <= {ecc({wc, VC, dt}), wc, VC, dt};
          lane_valid_o <= 4'hF;
          hs_request_o <= 1'b1;
          cnt          <= 16'h0;
          data_ready_o <= is_long && wc[15:2] != 14'd0;
          state        <= !is_long ? GAP : wc[15:2] != 14'd0 ? PAY : CRC;
        end
        PAY: begin
          hs_data_o    <= word;
          lane_valid_o <= 4'hF;
          hs_request_o <= 1'b1;
          crc          <= crc_step(crc, word);
          cnt          <= cnt + 16'd1;
          if (!data_valid_i) underflow_o <= 1'b1;
          if (cnt == {2'b00, wc[15:2]} - 16'd1) begin
            data_ready_o <= 1'b0;
            state        <= CRC;
          end
        end
        CRC: begin
          hs_data_o    <= {16'h0, crc};
          lane_valid_o <= 4'h3;
          hs_request_o <= 1'b1;
          cnt          <= 16'h0;
          state        <= GAP;
        end
        GAP: begin
          cnt <= cnt + 16'd1;
          if (cnt == GAP_LAST) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mipi_csi_packet_encoder.sv
// tb_mipi_csi_packet_encoder: random and directed packets checked cycle-by-cycle against a packet-level model
module tb_mipi_csi_packet_encoder;
  localparam int G = 8;
  typedef struct {
    logic        cr, dr, hr, uf, ce;
    logic [3:0]  lv;
    logic [31:0] hd0, hd1;
  } rec_t;
  logic        clk = 1'b0, reset_n = 1'b0, cmd_valid = 1'b0, data_valid = 1'b0;
  logic [1:0]  cmd_type = 2'd0;
  logic [5:0]  data_type = 6'd0;
  logic [15:0] word_count = 16'd0;
  logic [31:0] data = 32'd0;
  logic        cr0, cr1, dr0, dr1, hr0, hr1, uf0, uf1, ce0, ce1;
  logic [31:0] hd0, hd1;
  logic [3:0]  lv0, lv1;
  rec_t        q[$];
  logic [31:0] pay[$];
  logic [15:0] fn = 16'd0;
  logic        m_uf = 1'b0, chk_on = 1'b0;
  int          checks = 0, errors = 0;
  always #5 clk = ~clk;
  mipi_csi_packet_encoder #(.VC(2'd0), .FRAME_COUNT_EN(1'b1), .LP_GAP_CYCLES(G)) u1 (
    .clk_i(clk), .reset_in(reset_n), .cmd_valid_i(cmd_valid), .cmd_type_i(cmd_type),
    .data_type_i(data_type), .word_count_i(word_count), .cmd_ready_o(cr1), .data_i(data),
    .data_valid_i(data_valid), .data_ready_o(dr1), .hs_data_o(hd1), .lane_valid_o(lv1),
    .hs_request_o(hr1), .underflow_o(uf1), .cmd_error_o(ce1));
  mipi_csi_packet_encoder #(.VC(2'd0), .FRAME_COUNT_EN(1'b0), .LP_GAP_CYCLES(G)) u0 (
    .clk_i(clk), .reset_in(reset_n), .cmd_valid_i(cmd_valid), .cmd_type_i(cmd_type),
    .data_type_i(data_type), .word_count_i(word_count), .cmd_ready_o(cr0), .data_i(data),
    .data_valid_i(data_valid), .data_ready_o(dr0), .hs_data_o(hd0), .lane_valid_o(lv0),
    .hs_request_o(hr0), .underflow_o(uf0), .cmd_error_o(ce0));
  task automatic cmp(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, a, e);
    end
  endtask
  function automatic rec_t blank();
    rec_t r;
    r.cr = 1'b0; r.dr = 1'b0; r.hr = 1'b0; r.uf = m_uf; r.ce = 1'b0;
    r.lv = 4'h0; r.hd0 = 32'h0; r.hd1 = 32'h0;
    return r;
  endfunction
  function automatic rec_t idle();
    rec_t r;
    r = blank();
    r.cr = 1'b1;
    return r;
  endfunction
  function automatic rec_t burst(input logic [31:0] w0, input logic [31:0] w1, input logic [3:0] lv);
    rec_t r;
    r = blank();
    r.hd0 = w0; r.hd1 = w1; r.lv = lv; r.hr = 1'b1;
    return r;
  endfunction
  function automatic logic [31:0] hdr_m(input logic [15:0] w, input logic [5:0] d);
    logic [191:0] col;
    logic [23:0]  x;
    logic [5:0]   e;
    col = {8'h3B, 8'h37, 8'h2F, 8'h1F, 8'h38, 8'h34, 8'h32, 8'h31, 8'h2C, 8'h2A, 8'h29, 8'h26,
           8'h25, 8'h23, 8'h1C, 8'h1A, 8'h19, 8'h16, 8'h15, 8'h13, 8'h0E, 8'h0D, 8'h0B, 8'h07};
    x = {w, 2'b00, d};
    e = 6'd0;
    for (int i = 0; i < 24; i++) if (x[i]) e ^= col[8*i +: 6];
    return {2'b00, e, w, 2'b00, d};
  endfunction
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [7:0] x;
    x = b ^ c[7:0];
    x = x ^ (x << 4);
    return {x, c[15:8]} ^ {8'h0, x >> 4} ^ ({8'h0, x} << 3);
  endfunction
  always @(negedge clk) if (chk_on) begin
    rec_t e;
    if (q.size() > 0) e = q.pop_front();
    else e = idle();
    cmp("u1.cmd_ready", 32'(cr1), 32'(e.cr));   cmp("u0.cmd_ready", 32'(cr0), 32'(e.cr));
    cmp("u1.data_ready", 32'(dr1), 32'(e.dr));  cmp("u0.data_ready", 32'(dr0), 32'(e.dr));
    cmp("u1.hs_request", 32'(hr1), 32'(e.hr));  cmp("u0.hs_request", 32'(hr0), 32'(e.hr));
    cmp("u1.underflow", 32'(uf1), 32'(e.uf));   cmp("u0.underflow", 32'(uf0), 32'(e.uf));
    cmp("u1.cmd_error", 32'(ce1), 32'(e.ce));   cmp("u0.cmd_error", 32'(ce0), 32'(e.ce));
    cmp("u1.lane_valid", 32'(lv1), 32'(e.lv));  cmp("u0.lane_valid", 32'(lv0), 32'(e.lv));
    cmp("u1.hs_data", hd1, e.hd1);              cmp("u0.hs_data", hd0, e.hd0);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // drop: payload index sent with data_valid low; abort: payload index whose ready cycle asserts reset (-1 = none)
  task automatic send(input logic [1:0] ty, input logic [5:0] dtp, input logic [15:0] wcin, input int drop, input int abort);
    rec_t        r;
    logic        lng, bad;
    logic [15:0] w0, w1, c;
    logic [5:0]  di;
    logic [31:0] wd;
    int          n;
    lng = ty == 2'd2;
    bad = lng && wcin[1:0] != 2'd0;
    if (ty == 2'd0) fn = (fn == 16'hFFFF) ? 16'd1 : fn + 16'd1;
    w1 = lng ? {wcin[15:2], 2'b00} : fn;
    w0 = lng ? w1 : 16'd0;
    di = lng ? dtp : {5'd0, ty[0]};
    n  = lng ? int'(w1[15:2]) : 0;
    q.push_back(idle());
    if (ty == 2'd3) begin
      q.push_back(idle());
      r = idle(); r.ce = 1'b1; q.push_back(r);
    end else begin
      q.push_back(blank());
      r = burst(32'hB8B8B8B8, 32'hB8B8B8B8, 4'hF); r.ce = bad; q.push_back(r);
      r = burst(hdr_m(w0, di), hdr_m(w1, di), 4'hF); r.dr = n > 0; q.push_back(r);
      c = 16'hFFFF;
      for (int j = 0; j < n; j++) begin
        wd = (j == drop) ? 32'h0 : pay[j];
        if (j == drop) m_uf = 1'b1;
        for (int b = 0; b < 4; b++) c = crc_byte(c, wd[8*b +: 8]);
        r = burst(wd, wd, 4'hF); r.dr = j < n - 1; q.push_back(r);
      end
      if (lng) q.push_back(burst({16'h0, c}, {16'h0, c}, 4'h3));
      repeat (G) q.push_back(blank());
    end
    if (abort >= 0) begin
      while (q.size() > 4 + abort) void'(q.pop_back());
      m_uf = 1'b0;
      fn = 16'd0;
      q.push_back(blank());
      q.push_back(blank());
    end
    for (int t = 0; q.size() > 0; t++) begin
      cmd_valid = t == 0;
      cmd_type = ty; data_type = dtp; word_count = wcin;
      if (t >= 3 && t < 3 + n) begin
        data_valid = (t - 3) != drop;
        data = (t - 3) != drop ? pay[t - 3] : $urandom;
      end else begin
        data_valid = 1'($urandom);
        data = $urandom;
      end
      if (abort >= 0 && t == 3 + abort) reset_n = 1'b0;
      if (abort >= 0 && t == 5 + abort) reset_n = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
    data_valid = 1'b0;
    repeat ($urandom_range(0, 2)) tick();
  endtask
  initial begin
    logic [15:0] c;
    logic [31:0] wd;
    repeat (64) pay.push_back($urandom);
    tick();
    chk_on = 1'b1;
    q.push_back(blank());
    q.push_back(blank());
    tick();
    reset_n = 1'b1;
    tick();
    cmp("model_hdr_fe", hdr_m(16'h0, 6'h01), 32'h07000001);
    cmp("model_hdr_lp", hdr_m(16'd24, 6'h2B), 32'h1400182B);
    for (int i = 0; i < 3; i++) begin
      send(2'd0, 6'd0, 16'd0, -1, -1);
      send(2'd1, 6'd0, 16'd0, -1, -1);
    end
    pay[0] = 32'h020000FF; pay[1] = 32'h72F3DCB9; pay[2] = 32'h5AB8D4BB;
    pay[3] = 32'h7CC275C8; pay[4] = 32'hDF05F881; pay[5] = 32'h010000FF;
    c = 16'hFFFF;
    for (int j = 0; j < 6; j++) begin
      wd = pay[j];
      for (int b = 0; b < 4; b++) c = crc_byte(c, wd[8*b +: 8]);
    end
    cmp("model_crc_example", 32'(c), 32'h00F0);
    send(2'd2, 6'h2B, 16'd24, -1, -1);
    send(2'd2, 6'h12, 16'd0, -1, -1);
    send(2'd2, 6'h2A, 16'd10, -1, -1);
    send(2'd3, 6'h00, 16'd0, -1, -1);
    for (int j = 6; j < 64; j++) pay[j] = $urandom;
    send(2'd2, 6'h1E, 16'd16, 1, -1);
    send(2'd2, 6'h24, 16'd12, -1, -1);
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 64; j++) pay[j] = $urandom;
      send(2'($urandom_range(0, 3)), 6'($urandom), 16'($urandom_range(0, 100)),
           ($urandom_range(0, 4) == 0) ? $urandom_range(0, 5) : -1, -1);
    end
    force u1.frame_num = 16'hFFFF;
    force u0.frame_num = 16'hFFFF;
    tick();
    release u1.frame_num;
    release u0.frame_num;
    fn = 16'hFFFF;
    send(2'd0, 6'd0, 16'd0, -1, -1);
    send(2'd1, 6'd0, 16'd0, -1, -1);
    send(2'd2, 6'h2B, 16'd32, 1, 3);
    send(2'd0, 6'd0, 16'd0, -1, -1);
    send(2'd2, 6'h2C, 16'd8, -1, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
